// File: rtl/mouse_bus_responder.sv
// rtl/mouse_bus_responder.sv - PS/2 mouse status/X/Y bus responder with interrupt handshake
module mouse_bus_responder #(
  parameter logic [7:0] BASE_ADDR = 8'hA0
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_X,
  input  logic [7:0] MOUSE_Y,
  input  logic       MOUSE_PKT_VALID,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_X       = 3'd1;
  localparam logic [2:0] OFF_Y       = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd3;
  localparam logic [2:0] OFF_OVERRUN = 3'd4;

  logic [7:0] statusSnap;
  logic [7:0] xSnap;
  logic [7:0] ySnap;
  logic       irqEn;
  logic       pend;
  logic [7:0] overrun;
  logic [7:0] rdData;
  logic       rdOe;

  logic       hit;
  logic [2:0] offset;
  logic       wrHit;
  logic       rdHit;
  logic       ctrlWr;
  logic       clrPend;
  logic       overrunWr;
  logic       overrunInc;
  logic [7:0] rdMux;

  assign hit        = (BUS_ADDR[7:3] == BASE_ADDR[7:3]);
  assign offset     = BUS_ADDR[2:0];
  assign wrHit      = hit & BUS_WE;
  assign rdHit      = hit & ~BUS_WE;
  assign ctrlWr     = wrHit && (offset == OFF_CTRL);
  assign clrPend    = ctrlWr && BUS_DATA[1];
  assign overrunWr  = wrHit && (offset == OFF_OVERRUN);
  // Count only packets that land on an already-pending interrupt, using pre-edge PEND.
  assign overrunInc = MOUSE_PKT_VALID && pend && irqEn && (overrun != 8'hFF);

  // Read mux over the pre-update register values so a same-cycle packet is not visible yet.
  always_comb begin
    rdMux = 8'h00;
    case (offset)
      OFF_STATUS:  rdMux = statusSnap;
      OFF_X:       rdMux = xSnap;
      OFF_Y:       rdMux = ySnap;
      OFF_CTRL:    rdMux = {7'b0, irqEn};
      OFF_OVERRUN: rdMux = overrun;
      default:     rdMux = 8'h00;
    endcase
  end

  // Coherent snapshot of the whole packet; the newest packet always overwrites.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      statusSnap <= 8'h00;
      xSnap      <= 8'h00;
      ySnap      <= 8'h00;
    end else if (MOUSE_PKT_VALID) begin
      statusSnap <= MOUSE_STATUS;
      xSnap      <= MOUSE_X;
      ySnap      <= MOUSE_Y;
    end
  end

  // Control register and pending flag; a new packet beats a same-cycle ack or clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irqEn <= 1'b1;
      pend  <= 1'b0;
    end else begin
      if (ctrlWr) irqEn <= BUS_DATA[0];
      if (MOUSE_PKT_VALID && irqEn) pend <= 1'b1;
      else if (BUS_INTERRUPT_ACK || clrPend) pend <= 1'b0;
    end
  end

  // Saturating overrun counter; a processor write clears it even against a same-cycle increment.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      overrun <= 8'h00;
    end else if (overrunWr) begin
      overrun <= 8'h00;
    end else if (overrunInc) begin
      overrun <= overrun + 8'd1;
    end
  end

  // Registered read path: value and output enable captured on the hit edge, driven the next cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rdData <= 8'h00;
      rdOe   <= 1'b0;
    end else begin
      rdOe <= rdHit;
      if (rdHit) rdData <= rdMux;
    end
  end

  assign BUS_DATA            = rdOe ? rdData : 8'hzz;
  assign BUS_INTERRUPT_RAISE = pend;

endmodule
